// File: rtl/control_unit_pkg.sv
// Shared control encodings and the decode-to-execute bundle reused by the ID/EX and EX/MEM stages.
package control_unit_pkg;

  typedef enum logic [2:0] {
    PCSRC_NPC  = 3'd0,
    PCSRC_BEQ  = 3'd1,
    PCSRC_BNE  = 3'd2,
    PCSRC_JUMP = 3'd3,
    PCSRC_JR   = 3'd4
  } pcsrc_t;

  typedef enum logic [1:0] {
    ALUSRC_REG   = 2'd0,
    ALUSRC_IMM   = 2'd1,
    ALUSRC_LUI   = 2'd2,
    ALUSRC_SHAMT = 2'd3
  } alusrc_t;

  // An all-zero value of this struct is the pipeline bubble.
  typedef struct packed {
    logic [31:0] nPC;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic [31:0] lui;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  regDst;
    logic [3:0]  ALUOp;
    pcsrc_t      PCSrc;
    alusrc_t     ALUSrc;
    logic [1:0]  regSel;
    logic        dREN;
    logic        dWEN;
    logic        regWr;
    logic        halt;
  } id_ex_t;

  // rt is a source operand for register-register ALU ops, stores and compare branches.
  function automatic logic reads_rt(alusrc_t alusrc, logic dwen, pcsrc_t pcsrc);
    return (alusrc == ALUSRC_REG) || dwen || (pcsrc == PCSRC_BEQ) || (pcsrc == PCSRC_BNE);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary signals; master drives the decode side, slave is the ID/EX register.
interface id_ex_stage_if #(
  parameter int unsigned CNT_W = 16
);
  import control_unit_pkg::*;

  logic             ihit;
  logic             mem_stall;
  logic             flush;
  id_ex_t           de_in;
  id_ex_t           ex_out;
  logic             ex_valid;
  logic             freeze_id;
  logic             halted;
  logic [CNT_W-1:0] lu_count;

  modport master (
    output ihit, mem_stall, flush, de_in,
    input  ex_out, ex_valid, freeze_id, halted, lu_count
  );

  modport slave (
    input  ihit, mem_stall, flush, de_in,
    output ex_out, ex_valid, freeze_id, halted, lu_count
  );

endinterface

// File: rtl/hazard_unit.sv
// Load-use detection between the load in EX and the instruction in ID, plus the front-end freeze.
module hazard_unit
  import control_unit_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_dren_i,
  input  logic       ex_regwr_i,
  input  logic [4:0] ex_regdst_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  alusrc_t    id_alusrc_i,
  input  logic       id_dwen_i,
  input  pcsrc_t     id_pcsrc_i,
  input  logic       halted_i,
  input  logic       mem_stall_i,
  input  logic       flush_i,
  output logic       load_use_o,
  output logic       freeze_id_o
);

  logic ex_is_load;
  logic rs_match;
  logic rt_match;

  always_comb begin
    ex_is_load  = ex_valid_i && ex_dren_i && ex_regwr_i && (ex_regdst_i != '0);
    rs_match    = (ex_regdst_i == id_rs_i);
    rt_match    = (ex_regdst_i == id_rt_i) && reads_rt(id_alusrc_i, id_dwen_i, id_pcsrc_i);
    load_use_o  = ex_is_load && (rs_match || rt_match);
    // A taken branch discards the dependent instruction, so no need to hold it.
    freeze_id_o = halted_i || mem_stall_i || (load_use_o && !flush_i);
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with bubble insertion, stall/halt freeze and load-use counter.
module id_ex_stage
  import control_unit_pkg::*;
#(
  parameter int unsigned CNT_W          = 16,
  parameter bit          FREEZE_ON_HALT = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  id_ex_stage_if.slave  bus
);

  id_ex_t           ex_q, ex_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             freeze_id;

  hazard_unit u_hazard (
    .ex_valid_i  (valid_q),
    .ex_dren_i   (ex_q.dREN),
    .ex_regwr_i  (ex_q.regWr),
    .ex_regdst_i (ex_q.regDst),
    .id_rs_i     (bus.de_in.rs),
    .id_rt_i     (bus.de_in.rt),
    .id_alusrc_i (bus.de_in.ALUSrc),
    .id_dwen_i   (bus.de_in.dWEN),
    .id_pcsrc_i  (bus.de_in.PCSrc),
    .halted_i    (halted_q),
    .mem_stall_i (bus.mem_stall),
    .flush_i     (bus.flush),
    .load_use_o  (load_use),
    .freeze_id_o (freeze_id)
  );

  always_comb begin
    ex_d     = ex_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (halted_q && FREEZE_ON_HALT) begin
      // hold everything
    end else if (bus.mem_stall) begin
      // hold everything
    end else if (bus.flush) begin
      ex_d    = '0;
      valid_d = 1'b0;
    end else if (load_use) begin
      ex_d    = '0;
      valid_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.ihit) begin
      ex_d    = bus.de_in;
      valid_d = 1'b1;
      if (bus.de_in.halt) halted_d = 1'b1;
    end else begin
      ex_d    = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ex_q     <= ex_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ex_out    = ex_q;
  assign bus.ex_valid  = valid_q;
  assign bus.halted    = halted_q;
  assign bus.lu_count  = cnt_q;
  assign bus.freeze_id = freeze_id;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the 5-stage MIPS pipeline; captures the decode stage's `*_next` control/data bundle and presents it to the execute stage.
- Owns load-use hazard detection, bubble insertion on hazard/flush/ihit-miss, memory-stall freeze and halt capture.
- Also keeps a saturating load-use stall counter for performance checks.

Parameters:
- CNT_W, 16, width of load-use bubble counter
- FREEZE_ON_HALT, 1, when 1 the register holds permanently once a halting instruction has entered EX

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- ihit  input  1  fetch delivered a valid instruction into decode this cycle
- mem_stall  input  1  memory stage waiting on dhit; whole front end must hold
- flush  input  1  branch/jump resolved taken; discard the decode-stage instruction
- de_in  input  $bits(id_ex_t)  decode bundle: nPC, rdat1, rdat2, imm, lui, shamt, rs, rt, regDst, ALUOp, PCSrc, ALUSrc, regSel, dREN, dWEN, regWr, halt
- ex_out  output  $bits(id_ex_t)  registered bundle to execute
- ex_valid  output  1  ex_out holds a real instruction, not a bubble
- freeze_id  output  1  combinational; hold the PC and the fetch/decode register this cycle
- halted  output  1  halting instruction captured; pipeline front end is frozen
- lu_count  output  CNT_W  number of load-use bubbles inserted, saturating

Behaviour:
- Reset: asynchronous on RST high. ex_out is all zero, ex_valid=0, halted=0, lu_count=0. Reset mid-stall clears everything; no pending hazard survives reset.
- Bubble value: every field zero, which gives regWr=0, dREN=0, dWEN=0, halt=0 and PCSrc=PCSRC_NPC (encoding 0).
- load_use (combinational) requires all of the following:
  - ex_valid && ex_out.dREN && ex_out.regWr && ex_out.regDst != 0.
  - ex_out.regDst == de_in.rs, OR ex_out.regDst == de_in.rt while the ID instruction reads rt.
  - ID instruction reads rt when ALUSrc_in==ALUSRC_REG, or dWEN_in, or PCSrc_in in {PCSRC_BEQ, PCSRC_BNE}.
- freeze_id = halted | mem_stall | (load_use & ~flush).
- Update at each posedge CLK, first matching rule wins:
  1. halted && FREEZE_ON_HALT: hold all state.
  2. mem_stall: hold ex_out, ex_valid and lu_count unchanged.
  3. flush: load bubble, ex_valid=0. Flush beats load_use and the counter does not increment.
  4. load_use: load bubble, ex_valid=0, lu_count += 1 (saturates at all-ones, no wrap).
  5. ihit: load de_in, ex_valid=1. If de_in.halt=1, set halted on the same edge.
  6. otherwise: load bubble, ex_valid=0.
- Latency: exactly one cycle from de_in to ex_out when advancing.
- A load-use stall lasts exactly one bubble. After it, the load has left EX, so load_use deasserts and the held ID instruction advances on the next ihit.
- halted is only set through rule 5, never by a flushed or bubbled halt. A flush arriving in the same cycle as a halt in ID wins.
- The block does no arithmetic on data fields; widths pass through unchanged.

Decomposition:
- New package typedef in control_unit_pkg: id_ex_t, a packed struct with field order exactly as listed in the de_in port.
- Enum encodings PCSRC_NPC=0, PCSRC_BEQ, PCSRC_BNE and ALUSRC_REG, also in control_unit_pkg. The same struct is reused by the ex_mem stage.
- One natural sub-module: hazard_unit, a combinational block computing load_use and freeze_id from ex_out and de_in. Everything else lives in id_ex_stage.

Test Plan:
- Reset: assert RST mid-cycle with ex_valid=1 and lu_count=3 -> ex_out=0, ex_valid=0, lu_count=0, halted=0 immediately, before any clock edge.
- Normal advance: ihit=1, de_in.rdat1=0x12345678, regDst=5, regWr=1 -> next edge ex_out.rdat1=0x12345678, ex_valid=1, freeze_id=0.
- Load-use:
  - Setup: EX holds lw with regDst=8; ID holds add with rs=8.
  - Expect: freeze_id=1 for one cycle; bubble in EX; lu_count 0->1.
  - Next edge: add enters EX with ex_valid=1.
  - Repeat with an addi (ALUSrc imm) having rt=8 -> no stall.
- Flush priority: load_use and flush both true -> bubble loaded, lu_count unchanged, freeze_id=0.
- Mem stall: mem_stall=1 for 3 cycles with ihit=1 -> ex_out constant and freeze_id=1 throughout; resumes advancing on the cycle after mem_stall drops.
- Halt: ihit=1 with de_in.halt=1 -> halted=1 and ex_out.halt=1 after the edge; later ihit pulses leave ex_out unchanged. Same test with flush=1 in that cycle -> halted stays 0.
